pattern_hit_monitor: RTL

PATTERN_HIT_MONITOR -- requirements
Module: pattern_hit_monitor

---
 rtl/pattern_hit_monitor.sv | 106 ++++++++++
 1 files changed

// File: rtl/pattern_hit_monitor.sv
// Counts rising edges of an upstream pattern flag and reports each hit with the
// clk-cycle gap since the previous hit through a single-entry valid/ready slot.
module pattern_hit_monitor #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             pattern_detected,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [GAP_W-1:0] evt_gap,
  output logic [CNT_W-1:0] hit_count,
  output logic             overrun
);

  // state      | meaning
  // IDLE       | monitor disabled, not counting
  // WAIT_FIRST | enabled, no reference hit taken yet
  // RUN        | enabled, reference hit taken, gap counter running
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, RUN} state_t;

  localparam logic [GAP_W-1:0] GAP_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic             pd_q;
  logic             post_rst_q;
  logic [GAP_W-1:0] gap_q;

  logic             pd_prev_d;
  logic             hit_d;
  logic             accept_d;
  logic [GAP_W-1:0] hit_gap_d;

  // pd_q comes out of reset low; keep treating the previous level as low until
  // the first non-IDLE cycle so a flag already high at release still counts.
  assign pd_prev_d = pd_q & ~post_rst_q;
  assign hit_d     = pattern_detected & ~pd_prev_d & en & ~clear & (state_q != IDLE);
  assign hit_gap_d = (state_q == RUN) ? gap_q : '0;
  assign accept_d  = hit_d & (~evt_valid | evt_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pd_q       <= 1'b0;
      post_rst_q <= 1'b1;
      gap_q      <= '0;
      evt_valid  <= 1'b0;
      evt_gap    <= '0;
      hit_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      pd_q <= pattern_detected;
      if (state_q != IDLE) begin
        post_rst_q <= 1'b0;
      end

      if (clear) begin
        hit_count <= '0;
        overrun   <= 1'b0;
        evt_valid <= 1'b0;
        gap_q     <= '0;
        state_q   <= en ? WAIT_FIRST : IDLE;
      end else begin
        if (accept_d) begin
          evt_valid <= 1'b1;
          evt_gap   <= hit_gap_d;
        end else if (evt_valid && evt_ready) begin
          evt_valid <= 1'b0;
        end

        if (hit_d && evt_valid && !evt_ready) begin
          overrun <= 1'b1;
        end

        if (hit_d && hit_count != CNT_MAX) begin
          hit_count <= hit_count + 1'b1;
        end

        if (!en) begin
          state_q <= IDLE;
          gap_q   <= '0;
        end else begin
          case (state_q)
            IDLE:       state_q <= WAIT_FIRST;
            WAIT_FIRST: if (hit_d) state_q <= RUN;
            RUN:        state_q <= RUN;
            default:    state_q <= IDLE;
          endcase

          if (hit_d) begin
            gap_q <= GAP_W'(1);
          end else if (state_q == RUN) begin
            if (gap_q != GAP_MAX) gap_q <= gap_q + 1'b1;
          end else begin
            gap_q <= '0;
          end
        end
      end
    end
  end

endmodule
